// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and receiver state type.
// Functions operate on a 64-bit container; narrower counts are zero-extended.
package gray_pkg;

    localparam int GRAY_FN_W = 64;

    typedef enum logic {
        ST_UNLOCKED,
        ST_LOCKED
    } gray_rx_state_t;

    function automatic logic [GRAY_FN_W-1:0] f_bin2gray(input logic [GRAY_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_FN_W-1:0] f_gray2bin(input logic [GRAY_FN_W-1:0] g);
        logic [GRAY_FN_W-1:0] b;
        b = g;
        for (int i = GRAY_FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
// Zero latency; no flow control.
module gray2bin #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_cnt_rx.sv
// Gray counter link receiver: decodes samples, validates forward steps, counts violations.
// Latency 2 clk from sampled gray_in to outputs; no backpressure, ena only qualifies samples.
module gray_cnt_rx
    import gray_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_STEP = 1,
    parameter int DELTA_W  = 8,
    parameter int ERR_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [WIDTH-1:0]   gray_in,
    output logic               locked,
    output logic [WIDTH-1:0]   bin_out,
    output logic               bin_valid,
    output logic [DELTA_W-1:0] delta,
    output logic               step_err,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam logic [WIDTH-1:0] MAX_STEP_W = WIDTH'(MAX_STEP);

    logic               s1_vld;
    logic [WIDTH-1:0]   s1_gray;
    logic [WIDTH-1:0]   s1_bin;
    logic               s2_vld;
    logic [WIDTH-1:0]   s2_bin;

    gray_rx_state_t     state_q, state_d;
    logic [WIDTH-1:0]   ref_q, ref_d;
    logic [WIDTH-1:0]   bin_d;
    logic [DELTA_W-1:0] delta_d;
    logic               valid_d;
    logic               err_d;
    logic [ERR_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   diff;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray (s1_gray),
        .bin  (s1_bin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_gray <= '0;
            s2_vld  <= 1'b0;
            s2_bin  <= '0;
        end else begin
            s1_vld  <= ena;
            s1_gray <= gray_in;
            s2_vld  <= s1_vld;
            s2_bin  <= s1_bin;
        end
    end

    // Modular difference makes the all-ones -> zero wrap an ordinary +1 step.
    assign diff = s2_bin - ref_q;

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        bin_d   = bin_out;
        delta_d = delta;
        valid_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = err_cnt;
        if (s2_vld) begin
            case (state_q)
                ST_UNLOCKED: begin
                    state_d = ST_LOCKED;
                    ref_d   = s2_bin;
                    bin_d   = s2_bin;
                end
                ST_LOCKED: begin
                    if (diff == '0) begin
                        ref_d = ref_q;
                    end else if (diff <= MAX_STEP_W) begin
                        ref_d   = s2_bin;
                        bin_d   = s2_bin;
                        delta_d = DELTA_W'(diff);
                        valid_d = 1'b1;
                    end else begin
                        ref_d = s2_bin;
                        err_d = 1'b1;
                        if (err_cnt != '1) begin
                            cnt_d = err_cnt + 1'b1;
                        end
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_UNLOCKED;
            ref_q     <= '0;
            bin_out   <= '0;
            delta     <= '0;
            bin_valid <= 1'b0;
            step_err  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            bin_out   <= bin_d;
            delta     <= delta_d;
            bin_valid <= valid_d;
            step_err  <= err_d;
            err_cnt   <= cnt_d;
        end
    end

    assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_gray_cnt_rx.sv
// Bench for gray_cnt_rx: two builds (MAX_STEP 1 and 4) against a queue-based reference model.
module tb_gray_cnt_rx;
    import gray_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [3:0] gray_in = 4'd0;

    logic       locked_a, bin_valid_a, step_err_a;
    logic [3:0] bin_out_a;
    logic [7:0] delta_a;
    logic [1:0] err_cnt_a;
    logic       locked_b, bin_valid_b, step_err_b;
    logic [3:0] bin_out_b;
    logic [7:0] delta_b;
    logic [1:0] err_cnt_b;

    int checks = 0;
    int errors = 0;

    gray_cnt_rx #(.WIDTH(4), .MAX_STEP(1), .DELTA_W(8), .ERR_W(2)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .gray_in(gray_in),
        .locked(locked_a), .bin_out(bin_out_a), .bin_valid(bin_valid_a),
        .delta(delta_a), .step_err(step_err_a), .err_cnt(err_cnt_a)
    );

    gray_cnt_rx #(.WIDTH(4), .MAX_STEP(4), .DELTA_W(8), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .gray_in(gray_in),
        .locked(locked_b), .bin_out(bin_out_b), .bin_valid(bin_valid_b),
        .delta(delta_b), .step_err(step_err_b), .err_cnt(err_cnt_b)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] to_gray(input int b);
        logic [63:0] t;
        t = f_bin2gray(64'(b & 15));
        return t[3:0];
    endfunction

    function automatic logic [3:0] to_bin(input logic [3:0] g);
        logic [63:0] t;
        t = f_gray2bin({60'd0, g});
        return t[3:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples queue up and are applied two edges later.
    logic [4:0] pend[$];
    int         max_step[2] = '{1, 4};
    logic       m_locked[2];
    logic [3:0] m_bin[2];
    logic [3:0] m_ref[2];
    logic [7:0] m_delta[2];
    logic       m_valid[2];
    logic       m_err[2];
    int         m_cnt[2];

    always @(posedge clk) begin
        logic [4:0] s;
        int d;
        if (rst) begin
            pend.delete();
            for (int k = 0; k < 2; k++) begin
                m_locked[k] = 1'b0; m_bin[k] = 4'd0; m_ref[k] = 4'd0; m_delta[k] = 8'd0;
                m_valid[k] = 1'b0;  m_err[k] = 1'b0; m_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_valid[k] = 1'b0;
                m_err[k]   = 1'b0;
            end
            pend.push_back({ena, to_bin(gray_in)});
            if (pend.size() > 2) begin
                s = pend.pop_front();
                if (s[4]) begin
                    for (int k = 0; k < 2; k++) begin
                        if (!m_locked[k]) begin
                            m_locked[k] = 1'b1;
                            m_ref[k] = s[3:0];
                            m_bin[k] = s[3:0];
                        end else begin
                            d = (int'(s[3:0]) - int'(m_ref[k]) + 16) % 16;
                            if (d != 0 && d <= max_step[k]) begin
                                m_ref[k] = s[3:0];
                                m_bin[k] = s[3:0];
                                m_delta[k] = 8'(d);
                                m_valid[k] = 1'b1;
                            end else if (d != 0) begin
                                m_ref[k] = s[3:0];
                                m_err[k] = 1'b1;
                                if (m_cnt[k] < 3) m_cnt[k] = m_cnt[k] + 1;
                            end
                        end
                    end
                end
            end
        end
        #1;
        chk("locked_a", 32'(locked_a), 32'(m_locked[0]));
        chk("bin_out_a", 32'(bin_out_a), 32'(m_bin[0]));
        chk("bin_valid_a", 32'(bin_valid_a), 32'(m_valid[0]));
        chk("delta_a", 32'(delta_a), 32'(m_delta[0]));
        chk("step_err_a", 32'(step_err_a), 32'(m_err[0]));
        chk("err_cnt_a", 32'(err_cnt_a), 32'(m_cnt[0]));
        chk("locked_b", 32'(locked_b), 32'(m_locked[1]));
        chk("bin_out_b", 32'(bin_out_b), 32'(m_bin[1]));
        chk("bin_valid_b", 32'(bin_valid_b), 32'(m_valid[1]));
        chk("delta_b", 32'(delta_b), 32'(m_delta[1]));
        chk("step_err_b", 32'(step_err_b), 32'(m_err[1]));
        chk("err_cnt_b", 32'(err_cnt_b), 32'(m_cnt[1]));
        chk("pulse_excl_a", 32'(bin_valid_a & step_err_a), 32'd0);
    end

    task automatic drive(input logic r, input logic e, input logic [3:0] g);
        @(negedge clk);
        rst = r; ena = e; gray_in = g;
    endtask

    task automatic settle();
        drive(1'b0, 1'b0, gray_in);
        drive(1'b0, 1'b0, gray_in);
        @(negedge clk);
    endtask

    initial begin
        int cur;
        int r;
        repeat (3) drive(1'b1, 1'b0, 4'd0);
        chk("rst_locked", 32'(locked_a), 32'd0);
        chk("rst_bin_out", 32'(bin_out_a), 32'd0);

        drive(1'b0, 1'b1, 4'b0000);
        settle();
        chk("lock_locked", 32'(locked_a), 32'd1);
        chk("lock_bin_out", 32'(bin_out_a), 32'd0);
        chk("lock_no_valid", 32'(bin_valid_a), 32'd0);
        chk("lock_no_err", 32'(step_err_a), 32'd0);

        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b1, 4'b0011);
        drive(1'b0, 1'b1, 4'b0010);
        settle();
        chk("inc_bin_out", 32'(bin_out_a), 32'd3);
        chk("inc_valid", 32'(bin_valid_a), 32'd1);
        chk("inc_delta", 32'(delta_a), 32'd1);

        drive(1'b1, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b1, 4'b0000);
        settle();
        chk("wrap_bin_out", 32'(bin_out_a), 32'd0);
        chk("wrap_valid", 32'(bin_valid_a), 32'd1);
        chk("wrap_delta", 32'(delta_a), 32'd1);
        chk("wrap_no_err", 32'(step_err_a), 32'd0);

        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b1, 4'b0110);
        settle();
        chk("jump_err", 32'(step_err_a), 32'd1);
        chk("jump_cnt", 32'(err_cnt_a), 32'd1);
        chk("jump_bin_hold", 32'(bin_out_a), 32'd1);
        chk("jump4_delta", 32'(delta_b), 32'd3);
        chk("jump4_bin", 32'(bin_out_b), 32'd4);
        chk("jump4_no_err", 32'(step_err_b), 32'd0);

        drive(1'b0, 1'b1, 4'b0111);
        settle();
        chk("resync_bin", 32'(bin_out_a), 32'd5);
        chk("resync_delta", 32'(delta_a), 32'd1);

        drive(1'b0, 1'b1, 4'b0110);
        drive(1'b0, 1'b1, 4'b0010);
        drive(1'b0, 1'b1, 4'b0011);
        drive(1'b0, 1'b1, 4'b0001);
        settle();
        chk("sat_cnt", 32'(err_cnt_a), 32'd3);
        chk("sat_bin_hold", 32'(bin_out_a), 32'd5);

        repeat (8) drive(1'b0, 1'b0, 4'($urandom));
        settle();
        chk("frozen_bin", 32'(bin_out_a), 32'd5);
        chk("frozen_valid", 32'(bin_valid_a), 32'd0);
        chk("frozen_cnt", 32'(err_cnt_a), 32'd3);

        drive(1'b0, 1'b1, 4'b0011);
        drive(1'b1, 1'b1, 4'b0010);
        drive(1'b0, 1'b0, 4'd0);
        chk("midrst_locked", 32'(locked_a), 32'd0);
        chk("midrst_cnt", 32'(err_cnt_a), 32'd0);
        settle();
        chk("midrst_discard", 32'(locked_a), 32'd0);
        drive(1'b0, 1'b1, 4'b0011);
        settle();
        chk("relock_locked", 32'(locked_a), 32'd1);
        chk("relock_bin", 32'(bin_out_a), 32'd2);
        chk("relock_no_valid", 32'(bin_valid_a), 32'd0);

        cur = 2;
        repeat (3000) begin
            r = $urandom_range(0, 99);
            if (r < 8)       cur = $urandom_range(0, 15);
            else if (r < 13) cur = cur - 1;
            else if (r < 20) cur = cur + $urandom_range(2, 5);
            else             cur = cur + $urandom_range(0, 1);
            cur = cur & 15;
            drive(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, to_gray(cur));
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
